// File: rtl/calurom.sv
// Combined ALU and 16-entry result store. Each cycle either computes and stores
// the result at sel (rc=0) or reads back the entry at sel (rc=1). The result is registered.
module calurom #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             rc,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned DEPTH = 16;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] alu_c;

  // Combinational ALU; every result is truncated to WIDTH bits.
  always_comb begin
    alu_c = '0;
    unique case (sel)
      4'd0:  alu_c = a + b;
      4'd1:  alu_c = a - b;
      4'd2:  alu_c = a & b;
      4'd3:  alu_c = a | b;
      4'd4:  alu_c = a ^ b;
      4'd5:  alu_c = ~(a & b);
      4'd6:  alu_c = ~(a | b);
      4'd7:  alu_c = ~(a ^ b);
      4'd8:  alu_c = ~a;
      4'd9:  alu_c = a << 1;
      4'd10: alu_c = a >> 1;
      4'd11: alu_c = {a[WIDTH-2:0], a[WIDTH-1]};
      4'd12: alu_c = {a[0], a[WIDTH-1:1]};
      4'd13: alu_c = a + WIDTH'(1);
      4'd14: alu_c = a - WIDTH'(1);
      4'd15: alu_c = WIDTH'(a > b);
      default: alu_c = '0;
    endcase
  end

  // A read returns the entry as it stood before this edge.
  always_comb begin
    out_d = alu_c;
    if (rc) out_d = mem_q[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      out_q <= out_d;
      if (!rc) mem_q[sel] <= alu_c;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_calurom.sv
// Scoreboard bench for calurom: the driver pushes model expectations and the monitor
// compares them after each edge and again mid-cycle to confirm that out holds.
module tb_calurom;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   sel = '0;
  logic         rc = 1'b0;
  logic [W-1:0] out;

  calurom #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .rc(rc), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           chk;
    logic [W-1:0] exp;
    string        name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   pushed = 0;
  int   popped = 0;
  int   shadow [16];
  bit   known = 0;

  function automatic int ref_alu(input int s, input int x, input int y);
    case (s)
      0:  return (x + y) % 256;
      1:  return (x - y + 256) % 256;
      2:  return x & y;
      3:  return x | y;
      4:  return x ^ y;
      5:  return 255 - (x & y);
      6:  return 255 - (x | y);
      7:  return 255 - (x ^ y);
      8:  return 255 - x;
      9:  return (x * 2) % 256;
      10: return x / 2;
      11: return (x * 2) % 256 + x / 128;
      12: return x / 2 + (x % 2) * 128;
      13: return (x + 1) % 256;
      14: return (x + 255) % 256;
      default: return (x > y) ? 1 : 0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: out=0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic m, input logic [3:0] s,
                      input logic [W-1:0] av, input logic [W-1:0] bv, input string nm);
    exp_t e;
    int   v;
    @(negedge clk);
    rst = r; rc = m; sel = s; a = av; b = bv;
    e.name = nm;
    e.chk  = 1'b1;
    e.exp  = '0;
    if (r) begin
      for (int i = 0; i < 16; i++) shadow[i] = 0;
      known = 1;
    end else if (!known) begin
      e.chk = 1'b0;
    end else if (m) begin
      e.exp = W'(shadow[s]);
    end else begin
      v = ref_alu(int'(s), int'(av), int'(bv));
      shadow[s] = v;
      e.exp = W'(v);
    end
    q.push_back(e);
    pushed++;
  endtask

  // Monitor: pop one expectation per edge, then recheck at mid-cycle for hold.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        popped++;
        if (e.chk) begin
          check(e.name, out, e.exp);
          @(negedge clk);
          #1;
          check({e.name, "_hold"}, out, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, pushed=%0d popped=%0d", pushed, popped);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rs;
    // Unchecked pre-reset cycles
    step(0, 0, 4'd2, 8'h12, 8'h34, "prereset");
    step(0, 1, 4'd2, 8'h00, 8'h00, "prereset");
    // Reset then read every address
    step(1, 1, 4'd7, 8'h5A, 8'hA5, "reset");
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 8'hFF, 8'hFF, "rd_after_reset");
    // Compute then readback
    step(0, 0, 4'd0, 8'hF0, 8'h20, "add_f0_20");
    step(0, 1, 4'd0, 8'h00, 8'h00, "rd_add");
    // Wrap and shifts
    step(0, 0, 4'd1,  8'h05, 8'h07, "sub_wrap");
    step(0, 0, 4'd11, 8'h81, 8'h00, "rol");
    step(0, 0, 4'd12, 8'h81, 8'h00, "ror");
    step(0, 0, 4'd9,  8'h81, 8'h00, "shl");
    step(0, 0, 4'd10, 8'h81, 8'h00, "shr");
    step(0, 0, 4'd0,  8'hFF, 8'h01, "add_wrap");
    step(0, 0, 4'd1,  8'h00, 8'h01, "sub_zero");
    step(0, 0, 4'd14, 8'h00, 8'h00, "dec_wrap");
    step(0, 0, 4'd13, 8'hFF, 8'h00, "inc_wrap");
    step(0, 0, 4'd15, 8'h80, 8'h7F, "gt_true");
    step(0, 0, 4'd15, 8'h7F, 8'h7F, "gt_equal");
    // Overwrite: last write wins
    step(0, 0, 4'd4, 8'hAA, 8'hFF, "xor_first");
    step(0, 0, 4'd4, 8'h0F, 8'h01, "xor_second");
    step(0, 1, 4'd4, 8'h00, 8'h00, "rd_overwrite");
    // Reset mid-operation discards the pending write
    step(0, 0, 4'd3, 8'h99, 8'h00, "store_99");
    step(0, 1, 4'd3, 8'h00, 8'h00, "rd_99");
    step(1, 0, 4'd3, 8'h01, 8'h01, "reset_mid");
    step(0, 1, 4'd3, 8'h00, 8'h00, "rd_after_mid_reset");
    // Randomized sweep with occasional resets
    for (int i = 0; i < 100; i++) begin
      rs = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), rs,
           W'($urandom), W'($urandom), "random");
    end
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() == 0 && popped == pushed) passed++;
    else $display("FAIL drain: popped=%0d pushed=%0d", popped, pushed);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
